// File: rtl/tcdm_bank_init_arb.sv
// -----------------------------------------------------------------------------
// tcdm_bank_init_arb
//
// Front stage that sits directly upstream of one TCDM SRAM bank.
//
// After reset, or when init_req_i is pulsed while running, the block walks
// the whole bank and writes INIT_VALUE to every word, one word per cycle.
// Cluster traffic is stalled (never granted) while it does so. Otherwise
// every upstream request is granted in the cycle it is presented and is
// passed straight through to the bank pins. The response valid comes one
// cycle later, for reads and writes alike.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   init_req_i              single-cycle request to re-initialise the bank
//   init_busy_o             high while the init walk is in progress
//   init_done_o             one-cycle pulse in the first cycle after a walk
//   req_i/gnt_o             upstream request / grant
//   add_i                   upstream byte address (word bits are used only)
//   wen_i                   1 = read, 0 = write
//   be_i, data_i            upstream byte enables and write data
//   r_data_o, r_valid_o     upstream response (read data is 0 for writes)
//   bank_req_o .. bank_data_o  SRAM bank pins (chip enable, word address,
//                           read/write, byte enables, write data)
//   bank_r_data_i           SRAM read data, valid one cycle after a read
//
// ADDR_WIDTH must be larger than $clog2(BANK_SIZE)+2 so that at least one
// upper address bit exists to be ignored.
// -----------------------------------------------------------------------------
module tcdm_bank_init_arb #(
  parameter int unsigned           BANK_SIZE  = 256,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          init_req_i,
  output logic                          init_busy_o,
  output logic                          init_done_o,
  input  logic                          req_i,
  output logic                          gnt_o,
  input  logic [ADDR_WIDTH-1:0]         add_i,
  input  logic                          wen_i,
  input  logic [DATA_WIDTH/8-1:0]       be_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  output logic [DATA_WIDTH-1:0]         r_data_o,
  output logic                          r_valid_o,
  output logic                          bank_req_o,
  output logic [$clog2(BANK_SIZE)-1:0]  bank_add_o,
  output logic                          bank_wen_o,
  output logic [DATA_WIDTH/8-1:0]       bank_be_o,
  output logic [DATA_WIDTH-1:0]         bank_data_o,
  input  logic [DATA_WIDTH-1:0]         bank_r_data_i
);

  localparam int unsigned BANK_AW = $clog2(BANK_SIZE);
  localparam int unsigned BE_W    = DATA_WIDTH / 8;
  localparam logic [BANK_AW-1:0] LAST_ADDR = BANK_AW'(BANK_SIZE - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               r_state;
  logic [BANK_AW-1:0]   r_cnt;
  logic                 r_valid;
  logic                 r_rd;
  logic                 r_done;

  logic                 w_gnt;
  logic                 w_last;
  logic [BANK_AW-1:0]   w_word_add;
  logic                 w_unused_add;

  // Word address inside the bank: drop the byte offset and everything above
  // the bank size.
  assign w_word_add   = add_i[BANK_AW+1:2];
  assign w_unused_add = ^{add_i[ADDR_WIDTH-1:BANK_AW+2], add_i[1:0]};

  // A request is only granted while running; reset masks it immediately.
  assign w_gnt  = (~rst_i) & (r_state == ST_RUN) & req_i;
  assign w_last = (r_cnt == LAST_ADDR);

  // FSM, init counter and registered response/done flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_INIT;
      r_cnt   <= {BANK_AW{1'b0}};
      r_valid <= 1'b0;
      r_rd    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Response for whatever was granted this cycle; init writes are never
      // granted so they never produce a response.
      r_valid <= w_gnt;
      r_rd    <= w_gnt & wen_i;
      case (r_state)
        ST_INIT: begin
          // Counter wraps to 0 naturally after the last word.
          r_cnt <= r_cnt + BANK_AW'(1);
          if (w_last) begin
            r_state <= ST_RUN;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_INIT;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_done <= 1'b0;
          // The request presented alongside init_req_i is still granted
          // above; the walk starts on the following cycle.
          if (init_req_i) begin
            r_state <= ST_INIT;
            r_cnt   <= {BANK_AW{1'b0}};
          end else begin
            r_state <= ST_RUN;
            r_cnt   <= r_cnt;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= {BANK_AW{1'b0}};
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Bank pin multiplexer: init walk owns the bank, otherwise pass-through.
  always_comb begin
    bank_req_o  = 1'b0;
    bank_add_o  = {BANK_AW{1'b0}};
    bank_wen_o  = 1'b1;
    bank_be_o   = {BE_W{1'b0}};
    bank_data_o = {DATA_WIDTH{1'b0}};
    case (r_state)
      ST_INIT: begin
        bank_req_o  = ~rst_i;
        bank_add_o  = r_cnt;
        bank_wen_o  = 1'b0;
        bank_be_o   = {BE_W{1'b1}};
        bank_data_o = INIT_VALUE;
      end
      ST_RUN: begin
        bank_req_o  = (~rst_i) & req_i;
        bank_add_o  = w_word_add;
        bank_wen_o  = wen_i;
        bank_be_o   = be_i;
        bank_data_o = data_i;
      end
      default: begin
        bank_req_o  = 1'b0;
        bank_add_o  = {BANK_AW{1'b0}};
        bank_wen_o  = 1'b1;
        bank_be_o   = {BE_W{1'b0}};
        bank_data_o = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // Read data is only forwarded for read responses; writes answer with 0.
  always_comb begin
    if (r_valid & r_rd) begin
      r_data_o = bank_r_data_i;
    end else begin
      r_data_o = {DATA_WIDTH{1'b0}};
    end
  end

  assign gnt_o       = w_gnt;
  assign r_valid_o   = r_valid;
  assign init_busy_o = (r_state == ST_INIT);
  assign init_done_o = r_done;

endmodule

// File: tb/tb_tcdm_bank_init_arb.sv
// -----------------------------------------------------------------------------
// Bench for tcdm_bank_init_arb. A small SRAM model hangs off the bank pins.
// The reference model tracks only "initialising / running", the position in
// the init walk and the expected memory contents; expected responses go into
// a queue that an independent monitor drains whenever responses are due.
// -----------------------------------------------------------------------------
module tb_tcdm_bank_init_arb;

  localparam int BANK_SIZE = 256;
  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int BEW       = DW / 8;
  localparam logic [DW-1:0] INIT_VAL = 32'h0000_0000;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              init_req_i;
  logic              init_busy_o;
  logic              init_done_o;
  logic              req_i;
  logic              gnt_o;
  logic [AW-1:0]     add_i;
  logic              wen_i;
  logic [BEW-1:0]    be_i;
  logic [DW-1:0]     data_i;
  logic [DW-1:0]     r_data_o;
  logic              r_valid_o;
  logic              bank_req_o;
  logic [7:0]        bank_add_o;
  logic              bank_wen_o;
  logic [BEW-1:0]    bank_be_o;
  logic [DW-1:0]     bank_data_o;
  logic [DW-1:0]     bank_r_data_i;

  tcdm_bank_init_arb #(
    .BANK_SIZE (BANK_SIZE),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .INIT_VALUE(INIT_VAL)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .init_req_i   (init_req_i),
    .init_busy_o  (init_busy_o),
    .init_done_o  (init_done_o),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .add_i        (add_i),
    .wen_i        (wen_i),
    .be_i         (be_i),
    .data_i       (data_i),
    .r_data_o     (r_data_o),
    .r_valid_o    (r_valid_o),
    .bank_req_o   (bank_req_o),
    .bank_add_o   (bank_add_o),
    .bank_wen_o   (bank_wen_o),
    .bank_be_o    (bank_be_o),
    .bank_data_o  (bank_data_o),
    .bank_r_data_i(bank_r_data_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM bank model driven purely by the DUT's bank pins.
  logic [DW-1:0] sram [BANK_SIZE];
  always @(posedge clk_i) begin
    if (bank_req_o) begin
      if (bank_wen_o) begin
        bank_r_data_i <= sram[bank_add_o];
      end else begin
        for (int b = 0; b < BEW; b++)
          if (bank_be_o[b]) sram[bank_add_o][8*b +: 8] <= bank_data_o[8*b +: 8];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [BANK_SIZE];
  bit            m_init;     // bank is being initialised
  int            m_idx;      // words already written by the current walk
  bit            m_done;     // a walk completed at the last edge
  logic [DW-1:0] exp_q [$];  // expected r_data_o of pending responses
  bit            mon_en = 1'b0;

  // Advance the model by one clock edge using the inputs held over that edge.
  task automatic model_update();
    int w;
    m_done = 1'b0;
    if (rst_i) begin
      m_init = 1'b1;
      m_idx  = 0;
    end else if (m_init) begin
      m_idx++;
      if (m_idx == BANK_SIZE) begin
        m_init = 1'b0;
        m_idx  = 0;
        m_done = 1'b1;
        for (int i = 0; i < BANK_SIZE; i++) ref_mem[i] = INIT_VAL;
      end
    end else begin
      if (req_i) begin
        w = int'((add_i / 4) % BANK_SIZE);
        if (wen_i) begin
          exp_q.push_back(ref_mem[w]);
        end else begin
          exp_q.push_back(32'h0000_0000);
          for (int b = 0; b < BEW; b++)
            if (be_i[b]) ref_mem[w][8*b +: 8] = data_i[8*b +: 8];
        end
      end
      if (init_req_i) begin
        m_init = 1'b1;
        m_idx  = 0;
      end
    end
  endtask

  // Compare the combinational outputs of the current cycle with the model.
  task automatic check_comb();
    bit exp_gnt, exp_breq;
    if (rst_i)       begin exp_gnt = 1'b0; exp_breq = 1'b0; end
    else if (m_init) begin exp_gnt = 1'b0; exp_breq = 1'b1; end
    else             begin exp_gnt = req_i; exp_breq = req_i; end
    check("gnt", 64'(gnt_o), 64'(exp_gnt));
    check("bank_req", 64'(bank_req_o), 64'(exp_breq));
    check("init_busy", 64'(init_busy_o), 64'(rst_i | m_init));
    check("init_done", 64'(init_done_o), 64'(!rst_i && m_done));
    if (!rst_i && m_init) begin
      check("init_add", 64'(bank_add_o), 64'(m_idx));
      check("init_wen", 64'(bank_wen_o), 64'd0);
      check("init_be", 64'(bank_be_o), 64'hF);
      check("init_data", 64'(bank_data_o), 64'(INIT_VAL));
    end else if (!rst_i && req_i) begin
      check("run_add", 64'(bank_add_o), 64'((add_i / 4) % BANK_SIZE));
      check("run_wen", 64'(bank_wen_o), 64'(wen_i));
      check("run_be", 64'(bank_be_o), 64'(be_i));
      if (!wen_i) check("run_data", 64'(bank_data_o), 64'(data_i));
    end
  endtask

  // One clock cycle: inputs already set by the caller just after an edge.
  task automatic cycle();
    @(negedge clk_i);
    check_comb();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle();
    req_i = 1'b0; wen_i = 1'b1; add_i = '0; be_i = '0; data_i = '0; init_req_i = 1'b0;
  endtask

  task automatic drive_rand(input int p_req, input bit allow_init);
    logic [31:0] tmp;
    tmp    = $urandom();
    req_i  = ($urandom_range(99) < p_req);
    wen_i  = 1'($urandom_range(1));
    add_i  = (tmp & 32'hFFFF_FC03) | (32'($urandom_range(31)) << 2);
    be_i   = 4'($urandom_range(15));
    data_i = $urandom();
    init_req_i = allow_init && ($urandom_range(199) == 0);
  endtask

  // Monitor: a response is due exactly when the scoreboard holds one.
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("r_valid", 64'(r_valid_o), 64'(exp_q.size() != 0));
      if (r_valid_o && exp_q.size() != 0) begin
        check("r_data", 64'(r_data_o), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    for (int i = 0; i < BANK_SIZE; i++) begin
      sram[i]    = $urandom();
      ref_mem[i] = 32'hXXXX_XXXX;
    end
    bank_r_data_i = 32'h0000_0000;
    m_init = 1'b1; m_idx = 0; m_done = 1'b0;
    rst_i = 1'b1;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    mon_en = 1'b1;
    repeat (3) cycle();

    // First walk, random traffic ignored, reset hits at walk cycle 100.
    rst_i = 1'b0;
    for (int c = 0; c < 100; c++) begin drive_rand(80, 1'b1); cycle(); end
    rst_i = 1'b1;
    exp_q.delete();
    idle();
    repeat (2) cycle();
    rst_i = 1'b0;

    // Full walk with a read held pending and an ignored init_req mid-walk.
    for (int c = 0; c < BANK_SIZE + 1; c++) begin
      req_i = 1'b1; wen_i = 1'b1; add_i = 32'hABCD_0022; be_i = 4'hF; data_i = '0;
      init_req_i = (c == 50);
      cycle();
    end
    idle();
    cycle();

    // Directed write then read of byte address 0x10 (word 4).
    req_i = 1'b1; wen_i = 1'b0; add_i = 32'h0000_0010; be_i = 4'hF; data_i = 32'hDEAD_BEEF;
    cycle();
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h0000_0010; be_i = 4'hF; data_i = '0;
    cycle();
    idle();
    cycle();

    // Read together with init_req: read served, then walk, then word is 0.
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h0000_0010; init_req_i = 1'b1;
    cycle();
    idle();
    repeat (BANK_SIZE) cycle();
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h0000_0010;
    cycle();
    idle();
    cycle();

    // Random back-to-back traffic with occasional re-initialisation.
    for (int c = 0; c < 1500; c++) begin drive_rand(75, 1'b1); cycle(); end
    idle();
    repeat (3) cycle();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_init_arb.md
Name: tcdm_bank_init_arb

Overview:
- Per-bank front stage that sits directly upstream of one TCDM SRAM bank and drives its req/add/wen/be/data pins.
- After reset, or on request, it walks the whole bank writing INIT_VALUE, blocking cluster traffic while it does so.
- Otherwise it passes granted interconnect requests to the bank and generates the one-cycle-later response valid.
- One instance per bank, between the logarithmic interconnect and the bank memory.

Parameters:
- BANK_SIZE, 256, number of 32-bit words in the bank; power of two, >= 2.
- DATA_WIDTH, 32, data and word width in bits.
- ADDR_WIDTH, 32, byte address width on the upstream side.
- INIT_VALUE, 32'h0000_0000, word written to every location during init.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: asynchronous, active-high
- init_req_i  in  1  single-cycle request to re-initialise the bank
- init_busy_o  out  1  high while init is in progress
- init_done_o  out  1  one-cycle pulse when an init completes
- req_i  in  1  upstream request
- gnt_o  out  1  upstream grant
- add_i  in  ADDR_WIDTH  upstream byte address
- wen_i  in  1  1 = read, 0 = write
- be_i  in  DATA_WIDTH/8  byte enables
- data_i  in  DATA_WIDTH  write data
- r_data_o  out  DATA_WIDTH  read data
- r_valid_o  out  1  response valid
- bank_req_o  out  1  bank chip enable, active-high
- bank_add_o  out  $clog2(BANK_SIZE)  bank word address
- bank_wen_o  out  1  1 = read, 0 = write
- bank_be_o  out  DATA_WIDTH/8  bank byte enables
- bank_data_o  out  DATA_WIDTH  bank write data
- bank_r_data_i  in  DATA_WIDTH  bank read data, valid one cycle after a read request

Behaviour:
- Reset is asynchronous and active-high on rst_i.
- Registered state on reset: state=INIT, cnt=0, r_valid_o=0, init_done_o=0, init_busy_o=1.
- While rst_i is high, bank_req_o=0 and gnt_o=0.
- FSM states: INIT and RUN.
- INIT:
  - gnt_o=0; upstream requests are stalled, not dropped (req_i may be held).
  - Each cycle: bank_req_o=1, bank_wen_o=0, bank_be_o=all ones, bank_add_o=cnt, bank_data_o=INIT_VALUE; then cnt increments.
  - When cnt==BANK_SIZE-1, that write is issued and the next state is RUN; cnt wraps to 0.
  - init_done_o pulses in the first RUN cycle.
  - Init lasts exactly BANK_SIZE cycles; the first write occurs in the first clock edge window after rst_i deasserts.
  - init_req_i is ignored during INIT; it does not restart the count.
- RUN:
  - gnt_o=req_i.
  - bank_req_o=req_i, bank_add_o=add_i[$clog2(BANK_SIZE)+1:2], bank_wen_o=wen_i, bank_be_o=be_i, bank_data_o=data_i.
  - init_busy_o=0.
- Response path:
  - r_valid_o is registered and goes high the cycle after any granted request, read or write.
  - r_data_o = bank_r_data_i when r_valid_o is high and the granted request was a read; otherwise 0.
  - No response is ever generated for init writes.
- init_req_i in RUN moves the FSM to INIT at the next edge with cnt=0.
  - A req_i in the same cycle is still granted and executed.
  - Its response arrives the next cycle, concurrently with the first init write.
- Back-to-back requests in RUN: one per cycle, no bubbles.
- A reset asserted mid-init or mid-transaction immediately returns all state to reset values; any in-flight response is lost.
- Address bits above $clog2(BANK_SIZE)+1 and bits [1:0] are ignored.

Test Plan:
- Reset release with BANK_SIZE=256 -> 256 consecutive bank writes, addresses 0..255, data 0, be 4'hF; gnt_o=0 throughout; init_done_o pulses at cycle 256; init_busy_o falls with it.
- In RUN, write add=0x0000_0010, data=0xDEADBEEF, be=4'hF, then read add=0x10 -> bank_add_o=4; gnt same cycle; r_valid after 1 cycle each; read r_data_o=0xDEADBEEF.
- req_i held high during init -> gnt_o=0 until the first RUN cycle, then granted; exactly one response, no lost or duplicated request.
- init_req_i pulsed together with a read req -> read granted, response next cycle; init restarts, and a later read of that word returns 0 with INIT_VALUE=0.
- rst_i asserted at init cycle 100 for 2 cycles -> bank_req_o=0 during reset; after release, init restarts at address 0 and takes 256 cycles.
- init_req_i pulsed during INIT -> ignored; total init length stays 256 cycles; a single init_done_o pulse.
